// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default widths and the memory-map depth.
package mem_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;

   // Wait counter width covers the legal WAIT_STATES range 0..15.
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WAIT   = 2'b01,
      ACCESS = 2'b10,
      DONE   = 2'b11
   } state_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM: write-enable, read-enable with registered
// read data. Contents are never reset.
module ram_sp
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int MEM_WORDS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Write port and registered read port; read register only moves on i_re.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a read/write request in IDLE, inserts
// WAIT_STATES wait cycles, performs the RAM access, then holds done until
// both strobes are released (four-phase handshake).
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  read,
   input  logic                  write,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   output logic                  busy,
   output logic                  err
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_is_read;
   logic                    r_is_write;
   logic [31:0]             r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [WAIT_CNT_W-1:0]   r_wait_cnt;
   logic                    r_err;
   logic                    r_rd_valid;

   logic                    w_request;
   logic                    w_access_err;
   logic                    w_ram_we;
   logic                    w_ram_re;
   logic [DATA_WIDTH-1:0]   w_ram_q;

   assign w_request = read | write;

   // Address above the RAM, or an ambiguous read+write, is an error access.
   assign w_access_err = (|r_addr[31:ADDR_WIDTH]) | (r_is_read & r_is_write);
   assign w_ram_we     = (r_state == ACCESS) & r_is_write & ~w_access_err;
   assign w_ram_re     = (r_state == ACCESS) & r_is_read  & ~w_access_err;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_request) w_state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
         WAIT:    if (r_wait_cnt == '0) w_state_next = ACCESS;
         ACCESS:  w_state_next = DONE;
         DONE:    if (!read && !write) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Request latches, wait counter and per-access status.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_is_read  <= 1'b0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         if (r_state == IDLE && w_request) begin
            r_is_read  <= read;
            r_is_write <= write;
            r_addr     <= addr;
            r_wdata    <= wdata;
            r_wait_cnt <= WAIT_LOAD;
         end
         if (r_state == WAIT && r_wait_cnt != '0) begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
         end
         if (r_state == ACCESS) begin
            r_err <= w_access_err;
            // rdata is forced to zero by an error; a good write leaves it alone.
            if (w_access_err) begin
               r_rd_valid <= 1'b0;
            end else if (r_is_read) begin
               r_rd_valid <= 1'b1;
            end
         end
      end
   end

   ram_sp #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_clk   (clock),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (r_addr[ADDR_WIDTH-1:0]),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_q)
   );

   // The RAM read register is the rdata register; it is masked to zero
   // after reset or an error access because the RAM itself has no reset.
   assign rdata = r_rd_valid ? w_ram_q : '0;
   assign done  = (r_state == DONE);
   assign busy  = (r_state != IDLE);
   assign err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder. Four instances with
// WAIT_STATES = 1, 4, 0, 15 share one clock; a behavioural model tracks
// RAM contents and the last returned read data per instance.
module tb_mem_responder;

   localparam int NDUT = 4;

   logic        clk;
   logic        rst_s   [NDUT];
   logic        rd_s    [NDUT];
   logic        wr_s    [NDUT];
   logic [31:0] addr_s  [NDUT];
   logic [31:0] wdata_s [NDUT];
   logic [31:0] rdata_o [NDUT];
   logic        done_o  [NDUT];
   logic        busy_o  [NDUT];
   logic        err_o   [NDUT];

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: RAM words keyed by instance and address, plus the
   // rdata value each instance should currently present.
   logic [31:0] mdl_mem   [int];
   logic [31:0] mdl_rdata [NDUT];

   function automatic int ws_of(input int d);
      case (d)
         0:       return 1;
         1:       return 4;
         2:       return 0;
         default: return 15;
      endcase
   endfunction

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int WS = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 0 : 15;
      mem_responder #(
         .DATA_WIDTH  (32),
         .ADDR_WIDTH  (9),
         .WAIT_STATES (WS)
      ) u_dut (
         .clock (clk),
         .reset (rst_s[gi]),
         .read  (rd_s[gi]),
         .write (wr_s[gi]),
         .addr  (addr_s[gi]),
         .wdata (wdata_s[gi]),
         .rdata (rdata_o[gi]),
         .done  (done_o[gi]),
         .busy  (busy_o[gi]),
         .err   (err_o[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One complete handshake on instance d. Strobes are driven on a negedge,
   // done is polled on negedges, addr/wdata are scrambled once the request
   // has been sampled, and strobes are held 'hold' extra cycles past done.
   task automatic run_txn(input int d, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input string tag);
      bit          err_e;
      bit          known;
      logic [31:0] rd_e;
      int          key;
      int          lat;
      err_e = (r && w) || (a >= 32'd512);
      key   = d * 4096 + int'(a[8:0]);
      known = 1'b1;
      rd_e  = mdl_rdata[d];
      if (err_e) begin
         rd_e = 32'h0;
      end else if (r) begin
         if (mdl_mem.exists(key)) rd_e = mdl_mem[key];
         else                     known = 1'b0;
      end else begin
         mdl_mem[key] = wd;
      end

      @(negedge clk);
      rd_s[d]    = r;
      wr_s[d]    = w;
      addr_s[d]  = a;
      wdata_s[d] = wd;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            addr_s[d]  = $urandom;
            wdata_s[d] = $urandom;
         end
      end while (!done_o[d] && lat < 40);

      check_eq({tag, "_lat"},  lat, ws_of(d) + 2);
      check_eq({tag, "_err"},  32'(err_o[d]), 32'(err_e));
      check_eq({tag, "_busy"}, 32'(busy_o[d]), 32'd1);
      if (known) check_eq({tag, "_rdata"}, rdata_o[d], rd_e);

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq({tag, "_hold_done"}, 32'(done_o[d]), 32'd1);
         if (known) check_eq({tag, "_hold_rdata"}, rdata_o[d], rd_e);
      end

      rd_s[d] = 1'b0;
      wr_s[d] = 1'b0;
      @(negedge clk);
      check_eq({tag, "_rel_done"}, 32'(done_o[d]), 32'd0);
      check_eq({tag, "_rel_busy"}, 32'(busy_o[d]), 32'd0);
      if (known) mdl_rdata[d] = rd_e;
      $display("[TB] dut%0d %s r=%0d w=%0d addr=0x%08h wdata=0x%08h lat=%0d err=%0d rdata=0x%08h",
               d, tag, r, w, a, wd, lat, err_o[d], rdata_o[d]);
   endtask

   initial begin : stim
      logic [31:0] a;
      logic [31:0] wd;
      bit          r;
      bit          w;
      int          p;
      int          sel;

      for (int d = 0; d < NDUT; d++) begin
         rst_s[d]     = 1'b1;
         rd_s[d]      = 1'b0;
         wr_s[d]      = 1'b0;
         addr_s[d]    = '0;
         wdata_s[d]   = '0;
         mdl_rdata[d] = '0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check_eq("reset_rdata", rdata_o[d], 32'h0);
         check_eq("reset_done",  32'(done_o[d]), 32'd0);
         check_eq("reset_busy",  32'(busy_o[d]), 32'd0);
         check_eq("reset_err",   32'(err_o[d]), 32'd0);
         rst_s[d] = 1'b0;
      end

      // Write then read back, read held five cycles past done.
      run_txn(0, 1'b0, 1'b1, 32'h0000_007A, 32'h0000_1234, 0, "wr_7a");
      run_txn(0, 1'b1, 1'b0, 32'h0000_007A, 32'h0, 5, "rd_7a");

      // Prefill a small address pool used by the random phase.
      for (int i = 0; i < 18; i++) begin
         a = (i < 16) ? 32'(i) : ((i == 16) ? 32'h7A : 32'h1FF);
         run_txn(0, 1'b0, 1'b1, a, $urandom, 0, "prefill");
      end

      // Out-of-range write must not alias onto word 0.
      run_txn(0, 1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 0, "oor_wr");
      run_txn(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 0, "rd_0");

      // Read and write both asserted: error, rdata zero, RAM untouched.
      run_txn(0, 1'b1, 1'b1, 32'h0000_0005, 32'hCAFE_F00D, 1, "both");
      run_txn(0, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 0, "rd_5");

      // Randomized mix of reads, writes, ambiguous and out-of-range accesses.
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 99);
         p   = $urandom_range(0, 17);
         a   = (p < 16) ? 32'(p) : ((p == 16) ? 32'h7A : 32'h1FF);
         wd  = $urandom;
         r   = (sel < 45) || (sel >= 85 && sel < 93);
         w   = (sel >= 45 && sel < 93) || (sel >= 93 && sel[0]);
         if (sel >= 93) begin
            a = (32'($urandom_range(1, 8388607)) << 9) | 32'($urandom_range(0, 511));
            r = !w;
         end
         run_txn(0, r, w, a, wd, $urandom_range(0, 3), "rand");
      end

      // Reset in the 2nd wait cycle of a write: aborted, never committed.
      run_txn(1, 1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222, 0, "wr_10_old");
      @(negedge clk);
      wr_s[1]    = 1'b1;
      addr_s[1]  = 32'h0000_0010;
      wdata_s[1] = 32'h3333_4444;
      @(negedge clk);
      @(negedge clk);
      check_eq("abort_busy_before", 32'(busy_o[1]), 32'd1);
      rst_s[1] = 1'b1;
      #1;
      check_eq("abort_done", 32'(done_o[1]), 32'd0);
      check_eq("abort_busy", 32'(busy_o[1]), 32'd0);
      check_eq("abort_rdata", rdata_o[1], 32'h0);
      mdl_rdata[1] = '0;
      @(negedge clk);
      wr_s[1]  = 1'b0;
      rst_s[1] = 1'b0;
      run_txn(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, "rd_10_after_abort");

      // Latency at the wait-state extremes.
      run_txn(2, 1'b0, 1'b1, 32'h0000_0033, 32'hA5A5_0001, 0, "ws0_wr");
      run_txn(2, 1'b1, 1'b0, 32'h0000_0033, 32'h0, 0, "ws0_rd");
      run_txn(3, 1'b0, 1'b1, 32'h0000_01F0, 32'h5A5A_000F, 0, "ws15_wr");
      run_txn(3, 1'b1, 1'b0, 32'h0000_01F0, 32'h0, 2, "ws15_rd");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
